// File: rtl/obuf_accum.sv
// Banked output buffer for partial sums. Each bank has one write port and
// one read port. Writes either overwrite or accumulate into an entry through
// a short pipeline, and back-to-back accumulates to the same entry are
// forwarded. Reads have one cycle of latency. A read sees a write that
// commits at the same edge.
module obuf_accum #(
  parameter int NUM_BANKS    = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 256,
  parameter int SATURATE     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_BANKS-1:0]            bs_write_req,
  input  logic [NUM_BANKS-1:0]            bs_write_accum,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bs_write_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bs_write_data,
  input  logic [NUM_BANKS-1:0]            bs_read_req,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bs_read_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bs_read_data,
  output logic [NUM_BANKS-1:0]            bs_read_valid,
  output logic                            obuf_idle
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(BUFFER_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  genvar n;
  generate
    for (n = 0; n < NUM_BANKS; n++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [0:BUFFER_DEPTH-1];

      logic [ADDR_WIDTH-1:0] wr_addr;
      logic [DATA_WIDTH-1:0] wr_data;
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic                  wr_in_range;
      logic                  rd_in_range;

      logic                  pipe_valid;
      logic                  pipe_in_range;
      logic                  pipe_accum;
      logic [ADDR_WIDTH-1:0] pipe_addr;
      logic [DATA_WIDTH-1:0] pipe_data;
      logic [DATA_WIDTH-1:0] pipe_old;

      logic [DATA_WIDTH-1:0] sum_wrap;
      logic                  overflow;
      logic [DATA_WIDTH-1:0] pipe_result;
      logic                  pipe_commit;
      logic                  wr_hit;
      logic                  rd_hit;
      logic [DATA_WIDTH-1:0] old_next;

      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      assign wr_addr     = bs_write_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data     = bs_write_data[n*DATA_WIDTH +: DATA_WIDTH];
      assign rd_addr     = bs_read_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
      assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;

      // An out-of-range write still travels down the pipeline, but it never
      // writes memory and never forwards its result.
      assign pipe_commit = pipe_valid & pipe_in_range;
      assign wr_hit      = pipe_commit && (pipe_addr == wr_addr);
      assign rd_hit      = pipe_commit && (pipe_addr == rd_addr);

      // Result of the write in the second stage: overwrite value or signed sum,
      // optionally clamped on overflow.
      always_comb begin
        sum_wrap    = pipe_old + pipe_data;
        overflow    = (pipe_old[MSB] == pipe_data[MSB]) && (sum_wrap[MSB] != pipe_old[MSB]);
        pipe_result = pipe_data;
        if (pipe_accum) begin
          if ((SATURATE != 0) && overflow) begin
            pipe_result = pipe_old[MSB] ? MIN_VAL : MAX_VAL;
          end else begin
            pipe_result = sum_wrap;
          end
        end
      end

      // Old value for an incoming write. It is forwarded from the committing
      // stage so that chained accumulates see each other.
      always_comb begin
        old_next = '0;
        if (wr_in_range) begin
          old_next = wr_hit ? pipe_result : mem[wr_addr];
        end
      end

      // First pipeline stage. Reset drops any write in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid    <= 1'b0;
          pipe_in_range <= 1'b0;
          pipe_accum    <= 1'b0;
          pipe_addr     <= '0;
          pipe_data     <= '0;
          pipe_old      <= '0;
        end else begin
          pipe_valid <= bs_write_req[n];
          if (bs_write_req[n]) begin
            pipe_in_range <= wr_in_range;
            pipe_accum    <= bs_write_accum[n];
            pipe_addr     <= wr_addr;
            pipe_data     <= wr_data;
            pipe_old      <= old_next;
          end
        end
      end

      // Memory commit at the end of the second stage. Contents survive reset.
      always_ff @(posedge clk) begin
        if (pipe_commit) begin
          mem[pipe_addr] <= pipe_result;
        end
      end

      // Registered read port. A write committing at the same edge takes
      // priority. The data register keeps its value when no read is requested.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= bs_read_req[n];
          if (bs_read_req[n]) begin
            if (!rd_in_range) begin
              rd_data_q <= '0;
            end else if (rd_hit) begin
              rd_data_q <= pipe_result;
            end else begin
              rd_data_q <= mem[rd_addr];
            end
          end
        end
      end

      assign bs_read_data[n*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
      assign bs_read_valid[n]                         = rd_valid_q;
    end
  endgenerate

  // The buffer is idle only when no bank accepted a write in the previous
  // cycle. A write accepted then would be in its commit stage now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf_idle <= 1'b1;
    end else begin
      obuf_idle <= ~|bs_write_req;
    end
  end

endmodule

// File: tb/tb_obuf_accum.sv
// Self-checking bench for obuf_accum. It drives two instances with the same
// inputs: one with wrapping arithmetic and one with saturating arithmetic.
// The expected values come from directed vectors, hand sequences, and a
// sequential memory model.
module tb_obuf_accum;

  localparam int NB    = 4;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0]    wr_req, wr_acc, rd_req;
  logic [NB*AW-1:0] wr_addr, rd_addr;
  logic [NB*DW-1:0] wr_data;
  logic [NB*DW-1:0] rdata_w, rdata_s;
  logic [NB-1:0]    rvalid_w, rvalid_s;
  logic             idle_w, idle_s;

  always #5 clk = ~clk;

  obuf_accum #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
               .BUFFER_DEPTH(DEPTH), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset),
    .bs_write_req(wr_req), .bs_write_accum(wr_acc),
    .bs_write_addr(wr_addr), .bs_write_data(wr_data),
    .bs_read_req(rd_req), .bs_read_addr(rd_addr),
    .bs_read_data(rdata_w), .bs_read_valid(rvalid_w), .obuf_idle(idle_w));

  obuf_accum #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
               .BUFFER_DEPTH(DEPTH), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset),
    .bs_write_req(wr_req), .bs_write_accum(wr_acc),
    .bs_write_addr(wr_addr), .bs_write_data(wr_data),
    .bs_read_req(rd_req), .bs_read_addr(rd_addr),
    .bs_read_data(rdata_s), .bs_read_valid(rvalid_s), .obuf_idle(idle_s));

  typedef struct {
    int           bank;
    bit           wr;
    bit           acc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit           rd;
    logic [AW-1:0] ra;
    bit           chk;
    logic [DW-1:0] ew;
    logic [DW-1:0] es;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model. Writes apply in issue order, and the previous cycle's
  // write lands before a read.
  logic [DW-1:0] m_w [NB][256];
  logic [DW-1:0] m_s [NB][256];
  bit            m_known [NB][256];
  bit            p_valid [NB];
  bit            p_acc [NB];
  logic [AW-1:0] p_addr [NB];
  logic [DW-1:0] p_data [NB];
  bit            e_valid [NB];
  logic [DW-1:0] e_w [NB];
  logic [DW-1:0] e_s [NB];
  bit            e_known [NB];
  bit            e_idle;

  function automatic logic [DW-1:0] satAdd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    int maxv;
    int minv;
    maxv = (1 << (DW - 1)) - 1;
    minv = -(1 << (DW - 1));
    s = int'($signed(a)) + int'($signed(b));
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    return DW'(s);
  endfunction

  function automatic vec_t mkv(input int bank, input bit wr, input bit acc, input int wa,
                               input int wd, input bit rd, input int ra, input bit chk,
                               input int ew, input int es);
    vec_t v;
    v.bank = bank; v.wr = wr; v.acc = acc; v.wa = AW'(wa); v.wd = DW'(wd);
    v.rd = rd; v.ra = AW'(ra); v.chk = chk; v.ew = DW'(ew); v.es = DW'(es);
    return v;
  endfunction

  task automatic modelReset();
    for (int b = 0; b < NB; b++) begin
      p_valid[b] = 0;
      e_valid[b] = 0;
      e_w[b] = '0;
      e_s[b] = '0;
      e_known[b] = 1;
    end
    e_idle = 1;
  endtask

  task automatic modelEdge();
    for (int b = 0; b < NB; b++) begin
      if (p_valid[b] && (int'(p_addr[b]) < DEPTH)) begin
        if (p_acc[b]) begin
          m_w[b][p_addr[b]] = m_w[b][p_addr[b]] + p_data[b];
          m_s[b][p_addr[b]] = satAdd(m_s[b][p_addr[b]], p_data[b]);
        end else begin
          m_w[b][p_addr[b]] = p_data[b];
          m_s[b][p_addr[b]] = p_data[b];
          m_known[b][p_addr[b]] = 1;
        end
      end
      e_valid[b] = rd_req[b];
      if (rd_req[b]) begin
        if (int'(rd_addr[b*AW +: AW]) >= DEPTH) begin
          e_w[b] = '0;
          e_s[b] = '0;
          e_known[b] = 1;
        end else begin
          e_w[b] = m_w[b][rd_addr[b*AW +: AW]];
          e_s[b] = m_s[b][rd_addr[b*AW +: AW]];
          e_known[b] = m_known[b][rd_addr[b*AW +: AW]];
        end
      end
      p_valid[b] = wr_req[b];
      p_acc[b]   = wr_acc[b];
      p_addr[b]  = wr_addr[b*AW +: AW];
      p_data[b]  = wr_data[b*DW +: DW];
    end
    e_idle = (wr_req == '0);
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int b = 0; b < NB; b++) begin
      checkValue($sformatf("valid_wrap[%0d]", b), 32'(rvalid_w[b]), 32'(e_valid[b]));
      checkValue($sformatf("valid_sat[%0d]", b), 32'(rvalid_s[b]), 32'(e_valid[b]));
      if (e_known[b]) begin
        checkValue($sformatf("data_wrap[%0d]", b), 32'(rdata_w[b*DW +: DW]), 32'(e_w[b]));
        checkValue($sformatf("data_sat[%0d]", b), 32'(rdata_s[b*DW +: DW]), 32'(e_s[b]));
      end
    end
    checkValue("idle_wrap", 32'(idle_w), 32'(e_idle));
    checkValue("idle_sat", 32'(idle_s), 32'(e_idle));
  endtask

  task automatic clearInputs();
    wr_req = '0; wr_acc = '0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    wr_req[v.bank] = v.wr;
    wr_acc[v.bank] = v.acc;
    wr_addr[v.bank*AW +: AW] = v.wa;
    wr_data[v.bank*DW +: DW] = v.wd;
    rd_req[v.bank] = v.rd;
    rd_addr[v.bank*AW +: AW] = v.ra;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Reset goes high between edges, after the write cycle and before the commit edge.
  task automatic doReset();
    clearInputs();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic allBanks(input bit wr, input bit acc, input int wa, input int wd,
                          input bit rd, input int ra);
    for (int b = 0; b < NB; b++) begin
      wr_req[b] = wr;
      wr_acc[b] = acc;
      wr_addr[b*AW +: AW] = AW'(wa);
      wr_data[b*DW +: DW] = DW'(wd);
      rd_req[b] = rd;
      rd_addr[b*AW +: AW] = AW'(ra);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   budget;

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) begin
        m_w[b][a] = '0;
        m_s[b][a] = '0;
        m_known[b][a] = 0;
      end
    modelReset();
    clearInputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors. Expected data is the read response after the row's edge.
    tbl.push_back(mkv(2, 1, 0, 5, 'h11, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(2, 0, 0, 0, 0, 1, 5, 1, 'h11, 'h11));
    tbl.push_back(mkv(1, 1, 0, 3, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 'hFE, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 3, 1, 20, 20));
    tbl.push_back(mkv(1, 1, 0, 3, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 4, 99, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 6, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 3, 'hFE, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 3, 1, 20, 20));
    tbl.push_back(mkv(0, 1, 0, 0, 'h78, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 'h14, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 'h88, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 'hEC, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 1, 'h8C, 'h7F));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 1, 'h74, 'h80));
    tbl.push_back(mkv(3, 1, 0, 7, 'h33, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(3, 1, 0, 7, 'h5A, 1, 7, 1, 'h33, 'h33));
    tbl.push_back(mkv(3, 0, 0, 0, 0, 1, 7, 1, 'h5A, 'h5A));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      cycle();
      if (tbl[i].chk) begin
        checkValue($sformatf("tbl%0d_wrap", i), 32'(rdata_w[tbl[i].bank*DW +: DW]), 32'(tbl[i].ew));
        checkValue($sformatf("tbl%0d_sat", i), 32'(rdata_s[tbl[i].bank*DW +: DW]), 32'(tbl[i].es));
      end
    end

    // Reset arrives between a write and its commit. The old contents must survive.
    applyStimulus(mkv(0, 1, 0, 2, 'h10, 0, 0, 0, 0, 0));
    cycle();
    clearInputs();
    cycle();
    cycle();
    applyStimulus(mkv(0, 1, 0, 2, 'h44, 0, 0, 0, 0, 0));
    cycle();
    doReset();
    checkValue("rst_idle", 32'(idle_w), 32'd1);
    applyStimulus(mkv(0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    cycle();
    checkValue("rst_retained", 32'(rdata_w[0 +: DW]), 32'h10);

    // Every bank accumulates 1 into address 0, 256 times.
    clearInputs();
    allBanks(1, 0, 0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 256; k++) begin
      allBanks(1, 1, 0, 1, 0, 0);
      cycle();
    end
    clearInputs();
    budget = 0;
    do begin
      cycle();
      budget++;
    end while (!idle_w && budget < 10);
    checkValue("idle_after_burst", 32'(idle_w), 32'd1);
    allBanks(0, 0, 0, 0, 1, 0);
    cycle();
    for (int b = 0; b < NB; b++) begin
      checkValue($sformatf("burst_wrap[%0d]", b), 32'(rdata_w[b*DW +: DW]), 32'd0);
      checkValue($sformatf("burst_sat[%0d]", b), 32'(rdata_s[b*DW +: DW]), 32'd127);
    end
    allBanks(0, 0, 0, 0, 1, 250);
    cycle();
    for (int b = 0; b < NB; b++) begin
      checkValue($sformatf("oor_rd_valid[%0d]", b), 32'(rvalid_w[b]), 32'd1);
      checkValue($sformatf("oor_rd_data[%0d]", b), 32'(rdata_w[b*DW +: DW]), 32'd0);
    end
    allBanks(1, 0, 250, 'h77, 0, 0);
    cycle();
    allBanks(1, 1, 250, 'h05, 0, 0);
    cycle();
    clearInputs();
    cycle();
    allBanks(0, 0, 0, 0, 1, 0);
    cycle();
    for (int b = 0; b < NB; b++)
      checkValue($sformatf("oor_wr_keep[%0d]", b), 32'(rdata_s[b*DW +: DW]), 32'd127);

    // Random traffic checked against the model, with concentrated addresses
    // so that forwarding and write-first reads are exercised.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        allBanks(1, 0, 1, 'h3C, 0, 0);
        cycle();
        doReset();
      end
      for (int b = 0; b < NB; b++) begin
        wr_req[b] = ($urandom_range(0, 3) != 0);
        wr_acc[b] = ($urandom_range(0, 2) != 0);
        wr_addr[b*AW +: AW] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(200, 255))
                                                            : AW'($urandom_range(0, 3));
        wr_data[b*DW +: DW] = DW'($urandom);
        rd_req[b] = ($urandom_range(0, 1) != 0);
        rd_addr[b*AW +: AW] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(200, 255))
                                                            : AW'($urandom_range(0, 3));
      end
      cycle();
    end
    clearInputs();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
